// File: rtl/dram_port_arbiter.sv
// Two-master req/ack arbiter that sequences one access at a time onto the
// single data_ram port. Each access takes three cycles:
//   IDLE    latch the winning request
//   ACCESS  drive the RAM for one cycle
//   DONE    return a registered ack and read data
module dram_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int PRIO_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [3:0]        m0_sel,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_stall,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [3:0]        m1_sel,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_sel,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_e;

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                owner_q, owner_d;
  logic                ram_ce_q, ram_ce_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [3:0]          ram_sel_q, ram_sel_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic                m0_ack_q, m0_ack_d;
  logic                m1_ack_q, m1_ack_d;
  logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;

  logic any_req;
  logic pick_m1;

  assign any_req = m0_req | m1_req;

  // Round-robin hands a tie to the master that did not win last time.
  // Fixed priority always favours master 0.
  assign pick_m1 = m1_req & (~m0_req | ((PRIO_MODE == 0) & ~last_grant_q));

  // State and datapath registers; everything is cleared asynchronously so
  // that an access in flight is abandoned at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      ram_ce_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_sel_q    <= '0;
      ram_wdata_q  <= '0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      ram_ce_q     <= ram_ce_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_sel_q    <= ram_sel_d;
      ram_wdata_q  <= ram_wdata_d;
      m0_ack_q     <= m0_ack_d;
      m1_ack_q     <= m1_ack_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  // Next-state logic: one IDLE->ACCESS->DONE pass per granted request.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Register next values. Request fields are latched in IDLE; read data is
  // captured at the close of ACCESS. Acks are single-cycle pulses.
  always_comb begin
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    ram_ce_d     = ram_ce_q;
    ram_we_d     = ram_we_q;
    ram_addr_d   = ram_addr_q;
    ram_sel_d    = ram_sel_q;
    ram_wdata_d  = ram_wdata_q;
    m0_ack_d     = 1'b0;
    m1_ack_d     = 1'b0;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          ram_ce_d     = 1'b1;
          owner_d      = pick_m1;
          last_grant_d = pick_m1;
          ram_we_d     = pick_m1 ? m1_we    : m0_we;
          ram_addr_d   = pick_m1 ? m1_addr  : m0_addr;
          ram_sel_d    = pick_m1 ? m1_sel   : m0_sel;
          ram_wdata_d  = pick_m1 ? m1_wdata : m0_wdata;
        end
      end
      ACCESS: begin
        ram_ce_d = 1'b0;
        ram_we_d = 1'b0;
        if (owner_q) begin
          m1_ack_d   = 1'b1;
          m1_rdata_d = ram_we_q ? '0 : ram_rdata;
        end else begin
          m0_ack_d   = 1'b1;
          m0_rdata_d = ram_we_q ? '0 : ram_rdata;
        end
      end
      default: ;
    endcase
  end

  assign ram_ce    = ram_ce_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_sel   = ram_sel_q;
  assign ram_wdata = ram_wdata_q;
  assign m0_ack    = m0_ack_q;
  assign m1_ack    = m1_ack_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign m0_stall  = m0_req & ~m0_ack_q;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Bench for dram_port_arbiter. It runs a round-robin instance and a
// fixed-priority instance side by side, each with its own RAM model, and
// compares both against a transaction-level reference.
module tb_dram_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] a;
    logic [3:0]    s;
    logic [DW-1:0] w;
  } req_t;

  logic clk     = 1'b0;
  logic rst     = 1'b0;
  logic fill_en = 1'b1;
  always #5 clk = ~clk;

  logic          rq[2][2];
  logic          wr[2][2];
  logic [AW-1:0] ad[2][2];
  logic [3:0]    sl[2][2];
  logic [DW-1:0] wd[2][2];
  logic          ack[2][2];
  logic [DW-1:0] rd[2][2];
  logic          stall[2];
  logic          ce[2];
  logic          rwe[2];
  logic [AW-1:0] raddr[2];
  logic [3:0]    rsel[2];
  logic [DW-1:0] rwdata[2];
  logic [DW-1:0] rrdata[2];
  logic [DW-1:0] mem[2][256];

  function automatic logic [DW-1:0] pat(input int i);
    logic [31:0] iv;
    iv = 32'(i);
    return 32'h1234_5678 ^ (iv * 32'h9E37_79B9);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(g)) u_dut (
      .clk(clk), .rst(rst),
      .m0_req(rq[g][0]), .m0_we(wr[g][0]), .m0_addr(ad[g][0]), .m0_sel(sl[g][0]),
      .m0_wdata(wd[g][0]), .m0_ack(ack[g][0]), .m0_rdata(rd[g][0]), .m0_stall(stall[g]),
      .m1_req(rq[g][1]), .m1_we(wr[g][1]), .m1_addr(ad[g][1]), .m1_sel(sl[g][1]),
      .m1_wdata(wd[g][1]), .m1_ack(ack[g][1]), .m1_rdata(rd[g][1]),
      .ram_ce(ce[g]), .ram_we(rwe[g]), .ram_addr(raddr[g]), .ram_sel(rsel[g]),
      .ram_wdata(rwdata[g]), .ram_rdata(rrdata[g])
    );

    // data_ram: combinational read, byte-lane write at the clock edge.
    assign rrdata[g] = ce[g] ? mem[g][raddr[g][9:2]] : '0;

    always @(posedge clk) begin
      if (!rst) begin
        if (fill_en) for (int i = 0; i < 256; i++) mem[g][i] <= pat(i);
      end else if (ce[g] && rwe[g]) begin
        for (int b = 0; b < 4; b++)
          if (rsel[g][b]) mem[g][raddr[g][9:2]][8*b +: 8] <= rwdata[g][8*b +: 8];
      end
    end
  end

  // Reference model state, one set per instance.
  int            cyc = 0;
  int            nvec = 0;
  int            nerr = 0;
  int            acc_at[2];
  int            ack_at[2];
  int            nfree[2];
  int            own[2];
  logic          lastg[2];
  req_t          cur[2];
  logic [DW-1:0] exp_rd[2][2];
  logic [DW-1:0] gmem[2][256];

  // Master request queues and handshake state; index k = instance*2 + master.
  req_t mbuf[4][64];
  int   hd[4];
  int   tl[4];
  logic busy[4];
  logic saw_ack[4];

  // Ack log: owner and cycle of every observed ack.
  int lg_own[2][64];
  int lg_cyc[2][64];
  int lg_n[2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic push(input int k, input logic we, input logic [AW-1:0] a,
                      input logic [3:0] s, input logic [DW-1:0] w);
    req_t r;
    r.we = we; r.a = a; r.s = s; r.w = w;
    mbuf[k][tl[k] % 64] = r;
    tl[k]++;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      acc_at[d] = -10; ack_at[d] = -10; nfree[d] = 0; own[d] = 0;
      lastg[d] = 1'b1; cur[d] = '0; exp_rd[d][0] = '0; exp_rd[d][1] = '0;
    end
    for (int k = 0; k < 4; k++) begin
      hd[k] = 0; tl[k] = 0; busy[k] = 1'b0; saw_ack[k] = 1'b0;
      rq[k/2][k%2] = 1'b0; wr[k/2][k%2] = 1'b0; ad[k/2][k%2] = '0;
      sl[k/2][k%2] = '0; wd[k/2][k%2] = '0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("%s.d%0d.ram_ce", tag, d), ce[d], 0);
      check_eq($sformatf("%s.d%0d.ram_we", tag, d), rwe[d], 0);
      check_eq($sformatf("%s.d%0d.ram_addr", tag, d), raddr[d], 0);
      check_eq($sformatf("%s.d%0d.ram_sel", tag, d), rsel[d], 0);
      check_eq($sformatf("%s.d%0d.ram_wdata", tag, d), rwdata[d], 0);
      check_eq($sformatf("%s.d%0d.acks", tag, d), {ack[d][1], ack[d][0]}, 0);
      check_eq($sformatf("%s.d%0d.m0_rdata", tag, d), rd[d][0], 0);
      check_eq($sformatf("%s.d%0d.m1_rdata", tag, d), rd[d][1], 0);
      check_eq($sformatf("%s.d%0d.m0_stall", tag, d), stall[d], rq[d][0]);
    end
  endtask

  // One clock: check the outputs against the model, let the masters react,
  // then let the model arbitrate on the inputs that are now on the bus.
  task automatic step();
    logic ce_e;
    logic ack_e;
    int   w;
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (cyc == ack_at[d]) begin
        if (cur[d].we) begin
          for (int b = 0; b < 4; b++)
            if (cur[d].s[b]) gmem[d][cur[d].a[9:2]][8*b +: 8] = cur[d].w[8*b +: 8];
          exp_rd[d][own[d]] = '0;
        end else begin
          exp_rd[d][own[d]] = gmem[d][cur[d].a[9:2]];
        end
      end
      ce_e = (cyc == acc_at[d]);
      check_eq($sformatf("d%0d.ram_ce", d), ce[d], ce_e);
      check_eq($sformatf("d%0d.ram_we", d), rwe[d], ce_e & cur[d].we);
      if (ce_e) begin
        check_eq($sformatf("d%0d.ram_addr", d), raddr[d], cur[d].a);
        check_eq($sformatf("d%0d.ram_sel", d), rsel[d], cur[d].s);
        if (cur[d].we) check_eq($sformatf("d%0d.ram_wdata", d), rwdata[d], cur[d].w);
      end
      for (int m = 0; m < 2; m++) begin
        ack_e = (cyc == ack_at[d]) && (own[d] == m);
        check_eq($sformatf("d%0d.m%0d_ack", d, m), ack[d][m], ack_e);
        check_eq($sformatf("d%0d.m%0d_rdata", d, m), rd[d][m], exp_rd[d][m]);
        if (ack[d][m] && lg_n[d] < 64) begin
          lg_own[d][lg_n[d]] = m;
          lg_cyc[d][lg_n[d]] = cyc;
          lg_n[d]++;
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      int   d;
      int   m;
      req_t r;
      d = k / 2;
      m = k % 2;
      if (saw_ack[k]) begin
        busy[k] = 1'b0;
        rq[d][m] = 1'b0;
        wr[d][m] = 1'($urandom_range(0, 1));
        ad[d][m] = $urandom;
        sl[d][m] = 4'($urandom_range(0, 15));
        wd[d][m] = $urandom;
      end
      if (!busy[k] && hd[k] != tl[k]) begin
        r = mbuf[k][hd[k] % 64];
        hd[k]++;
        rq[d][m] = 1'b1; wr[d][m] = r.we; ad[d][m] = r.a; sl[d][m] = r.s; wd[d][m] = r.w;
        busy[k] = 1'b1;
      end
      saw_ack[k] = ack[d][m];
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("d%0d.m0_stall", d), stall[d],
               rq[d][0] & ~((cyc == ack_at[d]) && (own[d] == 0)));
      if (cyc >= nfree[d] && (rq[d][0] || rq[d][1])) begin
        w = (rq[d][1] && (!rq[d][0] || (d == 0 && !lastg[d]))) ? 1 : 0;
        own[d] = w;
        lastg[d] = 1'(w);
        cur[d].we = wr[d][w]; cur[d].a = ad[d][w]; cur[d].s = sl[d][w]; cur[d].w = wd[d][w];
        acc_at[d] = cyc + 1;
        ack_at[d] = cyc + 2;
        nfree[d] = cyc + 3;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int            n;
    int            exp_own;
    logic [DW-1:0] old0;
    logic [DW-1:0] old1;
    logic [DW-1:0] rv;
    model_reset();
    lg_n[0] = 0; lg_n[1] = 0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++) gmem[d][i] = pat(i);

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    fill_en = 1'b0;

    // Full-word write by m0, read back by m1.
    for (int d = 0; d < 2; d++) push(d*2 + 0, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF);
    run(5);
    for (int d = 0; d < 2; d++) push(d*2 + 1, 1'b0, 32'h10, 4'hF, 32'h0);
    run(5);
    for (int d = 0; d < 2; d++)
      check_eq($sformatf("d%0d.m1_readback", d), rd[d][1], 32'hDEAD_BEEF);

    // Single-byte write into lane 1, read back by m0, then by m1.
    for (int d = 0; d < 2; d++) push(d*2 + 0, 1'b1, 32'h20, 4'b0010, 32'h0000_AB00);
    run(5);
    for (int d = 0; d < 2; d++) push(d*2 + 0, 1'b0, 32'h20, 4'hF, 32'h0);
    run(5);
    for (int d = 0; d < 2; d++) begin
      rv = rd[d][0];
      check_eq($sformatf("d%0d.byte_lane1", d), rv[15:8], 8'hAB);
    end
    for (int d = 0; d < 2; d++) push(d*2 + 1, 1'b0, 32'h20, 4'hF, 32'h0);
    run(5);

    // Continuous contention: four back-to-back requests from each master.
    lg_n[0] = 0; lg_n[1] = 0;
    for (int i = 0; i < 4; i++)
      for (int d = 0; d < 2; d++) begin
        push(d*2 + 0, 1'b0, 32'($urandom_range(0, 255)) << 2, 4'hF, 32'h0);
        push(d*2 + 1, 1'b0, 32'($urandom_range(0, 255)) << 2, 4'hF, 32'h0);
      end
    run(32);
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("d%0d.contention_acks", d), lg_n[d], 8);
      for (int i = 0; i < 8 && i < lg_n[d]; i++) begin
        exp_own = (d == 0) ? (i % 2) : ((i < 4) ? 0 : 1);
        check_eq($sformatf("d%0d.grant%0d", d, i), lg_own[d][i], exp_own);
        if (i > 0)
          check_eq($sformatf("d%0d.spacing%0d", d, i), lg_cyc[d][i] - lg_cyc[d][i-1], 3);
      end
    end

    // Randomized traffic.
    for (int t = 0; t < 400; t++) begin
      for (int k = 0; k < 4; k++)
        if (tl[k] - hd[k] < 2 && $urandom_range(0, 3) == 0)
          push(k, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)) << 2,
               4'($urandom_range(0, 15)), $urandom);
      step();
    end
    run(12);

    // Reset in the middle of an m1 write: nothing may reach the RAM.
    for (int d = 0; d < 2; d++) push(d*2 + 1, 1'b1, 32'h40, 4'hF, ~gmem[d][16]);
    n = 0;
    do begin
      step();
      n++;
    end while (cyc != acc_at[0] && n < 10);
    check_eq("reach_access", cyc == acc_at[0], 1);
    old0 = gmem[0][16];
    old1 = gmem[1][16];
    @(negedge clk);
    model_reset();
    rst = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    check_eq("d0.write_abandoned", mem[0][16], old0);
    check_eq("d1.write_abandoned", mem[1][16], old1);

    // First tie after reset goes to m0.
    lg_n[0] = 0; lg_n[1] = 0;
    for (int d = 0; d < 2; d++) begin
      push(d*2 + 0, 1'b0, 32'h40, 4'hF, 32'h0);
      push(d*2 + 1, 1'b0, 32'h40, 4'hF, 32'h0);
    end
    run(12);
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("d%0d.post_reset_acks", d), lg_n[d], 2);
      check_eq($sformatf("d%0d.post_reset_first", d), lg_own[d][0], 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
